// File: rtl/serial_frame_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_receiver_if
// Description : Bundle of the serial-in / parallel-out signals of the stereo
//               frame receiver.
//               master : drives enable, frame, in_l, in_r; observes the words
//               slave  : the receiver itself (samples the serial lines,
//                        drives data_l, data_r, data_valid, frame_error, busy)
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_frame_receiver_if #(
   parameter int WIDTH = 16
);
   logic             enable;       // bit-slot qualifier
   logic             frame;        // MSB slot marker
   logic             in_l;         // left serial data
   logic             in_r;         // right serial data
   logic [WIDTH-1:0] data_l;       // last complete left word
   logic [WIDTH-1:0] data_r;       // last complete right word
   logic             data_valid;   // one-cycle new-word strobe
   logic             frame_error;  // sticky mid-word frame flag
   logic             busy;         // word partially received

   modport master (
      output enable, frame, in_l, in_r,
      input  data_l, data_r, data_valid, frame_error, busy
   );

   modport slave (
      input  enable, frame, in_l, in_r,
      output data_l, data_r, data_valid, frame_error, busy
   );
endinterface
`default_nettype wire

// File: rtl/serial_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_receiver
// Description : Stereo serial deserializer. Assembles one WIDTH-bit word per
//               channel per frame, MSB first, sampled on rising clk edges
//               with enable=1. Publishes data_l/data_r with a one-cycle
//               data_valid strobe on the edge that samples the LSB.
// Ports       : clk   - serial bit clock (rising edge)
//               clear - asynchronous active-high reset
//               bus   - serial_frame_receiver_if.slave (enable, frame,
//                       in_l, in_r in; data_l, data_r, data_valid,
//                       frame_error, busy out)
// Config      : SFR_FRAME_CHECK_EN - when defined, a frame seen mid-word
//               sets the sticky frame_error flag; otherwise frame_error is
//               tied low (the word is still resynchronised).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_receiver #(
   parameter int WIDTH = 16   // must be >= 2
) (
   input  wire logic             clk,
   input  wire logic             clear,
   serial_frame_receiver_if.slave bus
);

   localparam int                 c_cnt_w = $clog2(WIDTH);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
   localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

   localparam logic [0:0] c_idle = 1'b0;
   localparam logic [0:0] c_recv = 1'b1;

   logic [0:0]         r_state;
   logic [0:0]         w_next_state;
   logic [c_cnt_w-1:0] r_bit_cnt;
   // The shift registers only hold the WIDTH-1 bits received before the
   // current slot; the current slot's bit completes the word combinationally.
   logic [WIDTH-2:0]   r_shift_l;
   logic [WIDTH-2:0]   r_shift_r;
   logic [WIDTH-1:0]   r_data_l;
   logic [WIDTH-1:0]   r_data_r;
   logic               r_data_valid;
   logic               w_busy;
   logic [WIDTH-1:0]   w_word_l;
   logic [WIDTH-1:0]   w_word_r;
   logic               w_last;
   logic               w_qual_frame;
   logic               w_qual_data;

   assign w_word_l     = {r_shift_l, bus.in_l};
   assign w_word_r     = {r_shift_r, bus.in_r};
   assign w_last       = (r_bit_cnt == c_last);
   assign w_qual_frame = bus.enable & bus.frame;
   assign w_qual_data  = bus.enable & ~bus.frame & (r_state == c_recv);

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_idle: begin
            if (w_qual_frame) begin
               w_next_state = c_recv;
            end
         end
         c_recv: begin
            // A mid-word frame restarts the word and stays in RECV.
            if (w_qual_data && w_last) begin
               w_next_state = c_idle;
            end
         end
         default: w_next_state = c_idle;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_busy = (r_state == c_recv);
   end

   // ------------------------------------------------------------------------
   // Datapath: bit counter, shift registers and output words
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_bit_cnt    <= '0;
         r_shift_l    <= '0;
         r_shift_r    <= '0;
         r_data_l     <= '0;
         r_data_r     <= '0;
         r_data_valid <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         if (w_qual_frame) begin
            // New MSB, whether from IDLE or as a mid-word restart.
            r_shift_l <= (WIDTH-1)'(bus.in_l);
            r_shift_r <= (WIDTH-1)'(bus.in_r);
            r_bit_cnt <= c_one;
         end else if (w_qual_data) begin
            if (w_last) begin
               r_data_l     <= w_word_l;
               r_data_r     <= w_word_r;
               r_data_valid <= 1'b1;
               r_bit_cnt    <= '0;
            end else begin
               r_shift_l <= w_word_l[WIDTH-2:0];
               r_shift_r <= w_word_r[WIDTH-2:0];
               r_bit_cnt <= r_bit_cnt + c_one;
            end
         end
      end
   end

`ifdef SFR_FRAME_CHECK_EN
   logic r_frame_error;

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_frame_error <= 1'b0;
      end else if (w_qual_frame && (r_state == c_recv)) begin
         r_frame_error <= 1'b1;
      end
   end

   assign bus.frame_error = r_frame_error;
`else
   assign bus.frame_error = 1'b0;
`endif

   assign bus.data_l     = r_data_l;
   assign bus.data_r     = r_data_r;
   assign bus.data_valid = r_data_valid;
   assign bus.busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_receiver
// Description : Self-checking bench for serial_frame_receiver (WIDTH=16).
//               Table of directed vectors, directed multi-cycle sequences and
//               a randomized run against a word-level reference model.
//               Honours SFR_FRAME_CHECK_EN for the expected frame_error.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_receiver;

   localparam int WIDTH = 16;

`ifdef SFR_FRAME_CHECK_EN
   localparam logic c_err_on = 1'b1;
`else
   localparam logic c_err_on = 1'b0;
`endif

   logic clk = 1'b0;
   logic clear;

   serial_frame_receiver_if #(.WIDTH(WIDTH)) bus ();

   serial_frame_receiver #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             en;
      logic             fr;
      logic             l;
      logic             r;
      logic             exp_valid;
      logic             exp_busy;
      logic [WIDTH-1:0] exp_dl;
      logic [WIDTH-1:0] exp_dr;
   } vec_t;

   vec_t vecs[$];

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;
   int cyc_n    = 0;
   int          pulse_cyc[$];
   logic [15:0] pulse_l[$];
   logic [15:0] pulse_r[$];

   // Word-level reference model: a word in progress is a running number
   // (value*2 + bit) plus a count of the bits collected so far.
   bit          m_in_word;
   int          m_n;
   int unsigned m_acc_l, m_acc_r;
   logic [15:0] m_dl, m_dr;
   logic        m_valid, m_err;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_in_word = 1'b0;
      m_n       = 0;
      m_acc_l   = 0;
      m_acc_r   = 0;
      m_dl      = '0;
      m_dr      = '0;
      m_valid   = 1'b0;
      m_err     = 1'b0;
   endtask

   task automatic model_step(input logic en, input logic fr, input logic l, input logic r);
      m_valid = 1'b0;
      if (en) begin
         if (fr) begin
            if (m_in_word) m_err = c_err_on;
            m_in_word = 1'b1;
            m_n       = 1;
            m_acc_l   = 32'(l);
            m_acc_r   = 32'(r);
         end else if (m_in_word) begin
            m_acc_l = m_acc_l * 2 + 32'(l);
            m_acc_r = m_acc_r * 2 + 32'(r);
            m_n++;
            if (m_n == WIDTH) begin
               m_dl      = 16'(m_acc_l);
               m_dr      = 16'(m_acc_r);
               m_valid   = 1'b1;
               m_in_word = 1'b0;
            end
         end
      end
   endtask

   task automatic compare_model();
      chk("model_data_l", 32'(bus.data_l), 32'(m_dl));
      chk("model_data_r", 32'(bus.data_r), 32'(m_dr));
      chk("model_valid",  32'(bus.data_valid), 32'(m_valid));
      chk("model_err",    32'(bus.frame_error), 32'(m_err));
      chk("model_busy",   32'(bus.busy), 32'(m_in_word));
   endtask

   // One clock: drive, advance model, clock edge, sample 1 time unit later.
   task automatic cyc(input logic en, input logic fr, input logic l, input logic r);
      bus.enable = en;
      bus.frame  = fr;
      bus.in_l   = l;
      bus.in_r   = r;
      model_step(en, fr, l, r);
      @(posedge clk);
      #1;
      cyc_n++;
      if (bus.data_valid === 1'b1) begin
         pulse_cyc.push_back(cyc_n);
         pulse_l.push_back(bus.data_l);
         pulse_r.push_back(bus.data_r);
      end
      if (chk_en) compare_model();
   endtask

   task automatic send_word(input logic [15:0] wl, input logic [15:0] wr);
      for (int i = 0; i < 16; i++) cyc(1'b1, i == 0, wl[15-i], wr[15-i]);
   endtask

   task automatic clear_pulses();
      pulse_cyc.delete();
      pulse_l.delete();
      pulse_r.delete();
   endtask

   // Asynchronous clear between edges; outputs must drop immediately.
   task automatic do_clear();
      clear = 1'b1;
      model_clear();
      #2;
      chk("clr_data_l", 32'(bus.data_l), 32'h0);
      chk("clr_data_r", 32'(bus.data_r), 32'h0);
      chk("clr_valid",  32'(bus.data_valid), 32'h0);
      chk("clr_err",    32'(bus.frame_error), 32'h0);
      chk("clr_busy",   32'(bus.busy), 32'h0);
      clear = 1'b0;
   endtask

   function automatic void add_vec(input logic en, input logic fr, input logic l, input logic r,
                                   input logic ev, input logic eb,
                                   input logic [15:0] edl, input logic [15:0] edr);
      vecs.push_back('{en, fr, l, r, ev, eb, edl, edr});
   endfunction

   function automatic void build_table();
      logic [15:0] wl;
      logic [15:0] wr;
      logic        rl;
      wl = 16'hA5C3;
      wr = 16'h0001;
      // Nominal word from reset: result lands on the 16th edge.
      for (int i = 0; i < 16; i++) begin
         add_vec(1'b1, i == 0, wl[15-i], wr[15-i], i == 15, i != 15,
                 (i == 15) ? wl : 16'h0000, (i == 15) ? wr : 16'h0000);
      end
      // Qualified idle slot with lines high: strobe drops, words hold.
      add_vec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, wl, wr);
      // Same word with enable gaps after bits 5 and 12 (frame and data
      // toggled during the gaps must be ignored): strobe at raw slot 20.
      for (int i = 0; i < 16; i++) begin
         add_vec(1'b1, i == 0, wl[15-i], wr[15-i], i == 15, i != 15, wl, wr);
         if (i == 4 || i == 11) begin
            for (int g = 0; g < ((i == 4) ? 3 : 1); g++) begin
               rl = 1'($urandom);
               add_vec(1'b0, 1'b1, rl, ~rl, 1'b0, 1'b1, wl, wr);
            end
         end
      end
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear      = 1'b1;
      bus.enable = 1'b0;
      bus.frame  = 1'b0;
      bus.in_l   = 1'b0;
      bus.in_r   = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_data_l", 32'(bus.data_l), 32'h0);
      chk("rst_data_r", 32'(bus.data_r), 32'h0);
      chk("rst_valid",  32'(bus.data_valid), 32'h0);
      chk("rst_err",    32'(bus.frame_error), 32'h0);
      chk("rst_busy",   32'(bus.busy), 32'h0);
      clear = 1'b0;

      // ---------------- table-driven vectors ----------------
      build_table();
      foreach (vecs[i]) begin
         cyc(vecs[i].en, vecs[i].fr, vecs[i].l, vecs[i].r);
         chk($sformatf("vec%0d_valid", i), 32'(bus.data_valid), 32'(vecs[i].exp_valid));
         chk($sformatf("vec%0d_busy", i),  32'(bus.busy), 32'(vecs[i].exp_busy));
         chk($sformatf("vec%0d_dl", i),    32'(bus.data_l), 32'(vecs[i].exp_dl));
         chk($sformatf("vec%0d_dr", i),    32'(bus.data_r), 32'(vecs[i].exp_dr));
         chk($sformatf("vec%0d_err", i),   32'(bus.frame_error), 32'h0);
      end

      chk_en = 1'b1;

      // ---------------- back-to-back frames ----------------
      clear_pulses();
      send_word(16'h1234, 16'h8000);
      send_word(16'hFFFF, 16'h0000);
      send_word(16'h0000, 16'h0000);
      chk("b2b_pulses", 32'(pulse_cyc.size()), 32'd3);
      if (pulse_cyc.size() == 3) begin
         chk("b2b_gap1", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd16);
         chk("b2b_gap2", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd16);
         chk("b2b_w0", {pulse_l[0], pulse_r[0]}, 32'h1234_8000);
         chk("b2b_w1", {pulse_l[1], pulse_r[1]}, 32'hFFFF_0000);
         chk("b2b_w2", {pulse_l[2], pulse_r[2]}, 32'h0000_0000);
      end
      chk("b2b_err", 32'(bus.frame_error), 32'h0);

      // ---------------- mid-word frame at bit 9 ----------------
      clear_pulses();
      for (int i = 0; i < 8; i++) cyc(1'b1, i == 0, 1'b1, 1'(i));
      send_word(16'h7E7E, 16'h0F0F);
      chk("mid_pulses", 32'(pulse_cyc.size()), 32'd1);
      if (pulse_cyc.size() == 1) chk("mid_word", {pulse_l[0], pulse_r[0]}, 32'h7E7E_0F0F);
      chk("mid_err", 32'(bus.frame_error), 32'(c_err_on));

      // ---------------- idle noise ----------------
      clear_pulses();
      for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 1'(i), ~1'(i >> 1));
      chk("idle_pulses", 32'(pulse_cyc.size()), 32'd0);
      chk("idle_busy",   32'(bus.busy), 32'h0);
      chk("idle_words",  {bus.data_l, bus.data_r}, 32'h7E7E_0F0F);

      // ---------------- clear mid-word at bit 7 ----------------
      clear_pulses();
      for (int i = 0; i < 7; i++) cyc(1'b1, i == 0, 1'b1, 1'b1);
      do_clear();
      chk("rstmid_pulses", 32'(pulse_cyc.size()), 32'd0);
      send_word(16'h0042, 16'h0024);
      chk("rstmid_pulses2", 32'(pulse_cyc.size()), 32'd1);
      if (pulse_cyc.size() == 1) chk("rstmid_word", {pulse_l[0], pulse_r[0]}, 32'h0042_0024);

      // ---------------- randomized run against the model ----------------
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            do_clear();
         end else begin
            cyc(($urandom % 4) != 0, ($urandom % 18) == 0, 1'($urandom), 1'($urandom));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
